// File: rtl/display_pkg.sv
// Shared encodings for the display compositor: display modes, FSM states, colours.
package display_pkg;

    localparam logic [1:0] MODE_MAP   = 2'd0;
    localparam logic [1:0] MODE_GRAY  = 2'd1;
    localparam logic [1:0] MODE_FALSE = 2'd2;
    localparam logic [1:0] MODE_OFF   = 2'd3;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] WHITE = 12'hFFF;

    localparam int unsigned COORD_W = 10;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among valid requesters, priority rotates
// to the requester after the last one granted.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_valid,
    output logic [N-1:0] o_grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_gidx;
    logic             w_found;

    // Search from the pointer upward (wrapping) for the first valid requester.
    always_comb begin
        int unsigned idx;
        o_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!w_found && i_valid[idx]) begin
                o_grant[idx] = 1'b1;
                w_gidx       = PTR_W'(idx);
                w_found      = 1'b1;
            end
        end
    end

    // Move priority to the requester after the granted one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (w_gidx == PTR_W'(N - 1)) ? '0 : w_gidx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/display_compositor.sv
// Display compositor: arbitrates pixel writers onto the framebuffer write port,
// clears the framebuffer on mode changes and generates the VGA read path and rgb.
module display_compositor
    import display_pkg::*;
#(
    parameter int N_SRC    = 3,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 19,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int WIN_W    = 384,
    parameter int WIN_H    = 288,
    parameter int WIN_X    = 128,
    parameter int WIN_Y    = 96,
    parameter int RD_LAT   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                mode_req,
    input  logic                      frame_start,
    input  logic [10:0]               hcount,
    input  logic [10:0]               vcount,
    input  logic                      blank,
    input  logic [N_SRC-1:0]          src_valid,
    input  logic [N_SRC*10-1:0]       src_x,
    input  logic [N_SRC*10-1:0]       src_y,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    output logic [N_SRC-1:0]          src_ready,
    output logic [ADDR_W-1:0]         fb_waddr,
    output logic [DATA_W-1:0]         fb_wdata,
    output logic                      fb_we,
    output logic [ADDR_W-1:0]         fb_raddr,
    input  logic [DATA_W-1:0]         fb_rdata,
    output logic [11:0]               rgb,
    output logic [1:0]                mode_active,
    output logic                      busy,
    output logic [7:0]                drop_cnt
);

    localparam logic [10:0]       L_HA     = 11'(H_ACTIVE);
    localparam logic [10:0]       L_VA     = 11'(V_ACTIVE);
    localparam logic [10:0]       L_WW     = 11'(WIN_W);
    localparam logic [10:0]       L_WH     = 11'(WIN_H);
    localparam logic [10:0]       L_WX     = 11'(WIN_X);
    localparam logic [10:0]       L_WY     = 11'(WIN_Y);
    localparam logic [10:0]       L_WX_END = 11'(WIN_X + WIN_W);
    localparam logic [10:0]       L_WY_END = 11'(WIN_Y + WIN_H);
    localparam logic [ADDR_W-1:0] A_HA     = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] A_WW     = ADDR_W'(WIN_W);
    localparam logic [ADDR_W-1:0] LIM_FULL = ADDR_W'(H_ACTIVE * V_ACTIVE);
    localparam logic [ADDR_W-1:0] LIM_WIN  = ADDR_W'(WIN_W * WIN_H);

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_mode, w_mode_nxt;
    logic [ADDR_W-1:0]   r_clr_addr, w_clr_nxt;
    logic [ADDR_W-1:0]   w_limit;
    logic                w_clr_we;

    logic                r_fb_we;
    logic [ADDR_W-1:0]   r_fb_waddr;
    logic [DATA_W-1:0]   r_fb_wdata;
    logic [7:0]          r_drop_cnt;

    logic [N_SRC-1:0]    w_arb_valid;
    logic [N_SRC-1:0]    w_grant;
    logic                w_xfer;
    logic [9:0]          w_sel_x, w_sel_y;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_in_range;
    logic [ADDR_W-1:0]   w_row_w;
    logic [ADDR_W-1:0]   w_wr_addr;

    logic                w_inwin;
    logic [ADDR_W-1:0]   w_raddr_nxt;
    logic [ADDR_W-1:0]   r_fb_raddr;
    logic [RD_LAT:0]     r_blank_d;
    logic [RD_LAT:0]     r_inwin_d;
    logic [3:0]          w_hi;
    logic [11:0]         w_rgb_nxt;
    logic [11:0]         r_rgb;

    assign w_arb_valid = src_valid & {N_SRC{r_state == ST_RUN}};

    rr_arbiter #(
        .N (N_SRC)
    ) u_arb (
        .clk     (clk),
        .rst_n   (reset),
        .i_valid (w_arb_valid),
        .o_grant (w_grant)
    );

    assign w_xfer = |w_grant;

    // Clear length for the mode being entered.
    always_comb begin
        w_limit = '0;
        case (r_mode)
            MODE_MAP:   w_limit = LIM_FULL;
            MODE_GRAY,
            MODE_FALSE: w_limit = LIM_WIN;
            default:    w_limit = '0;
        endcase
    end

    // FSM next state: sweep clear addresses in CLEAR, watch for mode changes in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_clr_nxt   = r_clr_addr;
        w_clr_we    = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                if (w_limit == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_clr_we = 1'b1;
                    if (r_clr_addr == w_limit - ADDR_W'(1)) begin
                        w_state_nxt = ST_RUN;
                        w_clr_nxt   = '0;
                    end else begin
                        w_clr_nxt = r_clr_addr + ADDR_W'(1);
                    end
                end
            end
            default: begin
                if (frame_start && (mode_req != r_mode)) begin
                    w_mode_nxt  = mode_req;
                    w_clr_nxt   = '0;
                    w_state_nxt = ST_CLEAR;
                end
            end
        endcase
    end

    // FSM state, active mode and clear pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_CLEAR;
            r_mode     <= MODE_MAP;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_mode     <= w_mode_nxt;
            r_clr_addr <= w_clr_nxt;
        end
    end

    // Pick the granted source's coordinates and pixel.
    always_comb begin
        w_sel_x    = '0;
        w_sel_y    = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (w_grant[i]) begin
                w_sel_x    = src_x[i*COORD_W +: COORD_W];
                w_sel_y    = src_y[i*COORD_W +: COORD_W];
                w_sel_data = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Range check and linear write address for the current mode.
    always_comb begin
        w_in_range = 1'b0;
        w_row_w    = A_WW;
        case (r_mode)
            MODE_MAP: begin
                w_row_w    = A_HA;
                w_in_range = ({1'b0, w_sel_x} < L_HA) && ({1'b0, w_sel_y} < L_VA);
            end
            MODE_GRAY,
            MODE_FALSE: begin
                w_in_range = ({1'b0, w_sel_x} < L_WW) && ({1'b0, w_sel_y} < L_WH);
            end
            default: w_in_range = 1'b0;
        endcase
        w_wr_addr = ADDR_W'(w_sel_y) * w_row_w + ADDR_W'(w_sel_x);
    end

    // Framebuffer write port: clear sweep, accepted pixel, or idle; count drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fb_we    <= 1'b0;
            r_fb_waddr <= '0;
            r_fb_wdata <= '0;
            r_drop_cnt <= '0;
        end else if (w_clr_we) begin
            r_fb_we    <= 1'b1;
            r_fb_waddr <= r_clr_addr;
            r_fb_wdata <= '0;
        end else if (w_xfer && w_in_range) begin
            r_fb_we    <= 1'b1;
            r_fb_waddr <= w_wr_addr;
            r_fb_wdata <= w_sel_data;
        end else begin
            r_fb_we <= 1'b0;
            if (w_xfer && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // Read address from the VGA beam position.
    always_comb begin
        w_inwin = (hcount >= L_WX) && (hcount < L_WX_END) &&
                  (vcount >= L_WY) && (vcount < L_WY_END);
        w_raddr_nxt = '0;
        if (r_mode == MODE_MAP) begin
            w_raddr_nxt = ADDR_W'(vcount) * A_HA + ADDR_W'(hcount);
        end else if (w_inwin) begin
            w_raddr_nxt = ADDR_W'(vcount - L_WY) * A_WW + ADDR_W'(hcount - L_WX);
        end
    end

    // Register the read address and delay blank/window flags to line up with fb_rdata.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fb_raddr <= '0;
            r_blank_d  <= '0;
            r_inwin_d  <= '0;
        end else begin
            r_fb_raddr <= w_raddr_nxt;
            r_blank_d  <= {r_blank_d[RD_LAT-1:0], blank};
            r_inwin_d  <= {r_inwin_d[RD_LAT-1:0], w_inwin};
        end
    end

    assign w_hi = fb_rdata[DATA_W-1 -: 4];

    // Map returned pixel data to a colour for the active mode.
    always_comb begin
        w_rgb_nxt = BLACK;
        if (!r_blank_d[RD_LAT] && (r_state == ST_RUN)) begin
            case (r_mode)
                MODE_MAP:   w_rgb_nxt = (fb_rdata == '1) ? BLACK : WHITE;
                MODE_GRAY:  w_rgb_nxt = r_inwin_d[RD_LAT] ? {w_hi, w_hi, w_hi} : BLACK;
                MODE_FALSE: w_rgb_nxt = r_inwin_d[RD_LAT] ? {w_hi, ~w_hi, 4'h8} : BLACK;
                default:    w_rgb_nxt = BLACK;
            endcase
        end
    end

    // Output colour register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rgb <= BLACK;
        end else begin
            r_rgb <= w_rgb_nxt;
        end
    end

    assign src_ready   = w_grant;
    assign fb_we       = r_fb_we;
    assign fb_waddr    = r_fb_waddr;
    assign fb_wdata    = r_fb_wdata;
    assign fb_raddr    = r_fb_raddr;
    assign rgb         = r_rgb;
    assign mode_active = r_mode;
    assign busy        = (r_state == ST_CLEAR);
    assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_display_compositor.sv
// Scoreboard bench for display_compositor: expected framebuffer writes are queued
// by the stimulus and popped by a monitor; timing and colour checked directly.
module tb_display_compositor;

    localparam int N   = 3;
    localparam int DW  = 8;
    localparam int AW  = 19;
    localparam int HA  = 640;
    localparam int VA  = 8;
    localparam int WW  = 384;
    localparam int WH  = 8;
    localparam int WX  = 128;
    localparam int WY  = 96;
    localparam int RDL = 2;

    logic            clk;
    logic            reset;
    logic [1:0]      mode_req;
    logic            frame_start;
    logic [10:0]     hcount, vcount;
    logic            blank;
    logic [N-1:0]    src_valid;
    logic [N*10-1:0] src_x, src_y;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]    src_ready;
    logic [AW-1:0]   fb_waddr, fb_raddr;
    logic [DW-1:0]   fb_wdata, fb_rdata, q1;
    logic            fb_we;
    logic [11:0]     rgb;
    logic [1:0]      mode_active;
    logic            busy;
    logic [7:0]      drop_cnt;

    display_compositor #(
        .N_SRC    (N),
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .WIN_W    (WW),
        .WIN_H    (WH),
        .WIN_X    (WX),
        .WIN_Y    (WY),
        .RD_LAT   (RDL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode_req    (mode_req),
        .frame_start (frame_start),
        .hcount      (hcount),
        .vcount      (vcount),
        .blank       (blank),
        .src_valid   (src_valid),
        .src_x       (src_x),
        .src_y       (src_y),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .fb_waddr    (fb_waddr),
        .fb_wdata    (fb_wdata),
        .fb_we       (fb_we),
        .fb_raddr    (fb_raddr),
        .fb_rdata    (fb_rdata),
        .rgb         (rgb),
        .mode_active (mode_active),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Framebuffer model with two-cycle read latency.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (fb_we === 1'b1) mem[fb_waddr] <= fb_wdata;
        q1       <= mem[fb_raddr];
        fb_rdata <= q1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Expected write runs: len consecutive addresses from addr, all with data.
    typedef struct {
        int unsigned addr;
        logic [DW-1:0] data;
        int unsigned len;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned mon_off = 0;
    logic        mon_bad = 1'b0;
    logic [AW-1:0] bad_addr, bad_eaddr;
    logic [DW-1:0] bad_data;

    task automatic push_w(input int unsigned a, input logic [DW-1:0] d, input int unsigned n);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.len  = n;
        exp_q.push_back(e);
    endtask

    // Monitor: every framebuffer write is matched against the queue head.
    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_write got addr=%0d data=%0h exp none", fb_waddr, fb_wdata);
            end else begin
                mon_e = exp_q[0];
                if ((fb_waddr !== AW'(mon_e.addr + mon_off)) || (fb_wdata !== mon_e.data)) begin
                    if (!mon_bad) begin
                        mon_bad   = 1'b1;
                        bad_addr  = fb_waddr;
                        bad_data  = fb_wdata;
                        bad_eaddr = AW'(mon_e.addr + mon_off);
                    end
                end
                mon_off++;
                if (mon_off == mon_e.len) begin
                    checks++;
                    if (mon_bad) begin
                        errors++;
                        $display("FAIL sb_write got addr=%0d data=%0h exp addr=%0d data=%0h",
                                 bad_addr, bad_data, bad_eaddr, mon_e.data);
                    end
                    void'(exp_q.pop_front());
                    mon_off = 0;
                    mon_bad = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic [9:0] x, input logic [9:0] y,
                           input logic [DW-1:0] d);
        src_valid[i]        = v;
        src_x[i*10 +: 10]   = x;
        src_y[i*10 +: 10]   = y;
        src_data[i*DW +: DW] = d;
    endtask

    // Count edges until busy drops; optionally pulse frame_start (mode 2) at edge fs_at.
    task automatic count_busy(input int fs_at, output int n);
        n = 0;
        while (busy && n < 20000) begin
            frame_start = (n == fs_at);
            if (n == fs_at) mode_req = 2'd2;
            step();
            n++;
        end
        frame_start = 1'b0;
    endtask

    task automatic change_mode(input logic [1:0] m);
        mode_req    = m;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_src_ready", 32'(src_ready), 0);
        check("rst_fb_we", 32'(fb_we), 0);
        check("rst_fb_waddr", 32'(fb_waddr), 0);
        check("rst_fb_wdata", 32'(fb_wdata), 0);
        check("rst_fb_raddr", 32'(fb_raddr), 0);
        check("rst_rgb", 32'(rgb), 0);
        check("rst_mode_active", 32'(mode_active), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        check("rst_busy", 32'(busy), 1);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int n;
    int tb_ptr;
    int gcnt[N];

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        reset = 1'b0; mode_req = 2'd0; frame_start = 1'b0;
        hcount = '0; vcount = '0; blank = 1'b0;
        src_valid = '0; src_x = '0; src_y = '0; src_data = '0;
        tb_ptr = 0;

        repeat (3) step();
        check_reset_outputs();

        // Power-up clear of the full-screen map.
        push_w(0, 8'h00, HA * VA);
        @(negedge clk);
        reset = 1'b1;
        count_busy(-1, n);
        check("clear_len_mode0", n, HA * VA);
        check("mode_after_clear", 32'(mode_active), 0);

        // Source 1 writes x=5,y=2,FF in mode 0.
        set_src(1, 1'b1, 10'd5, 10'd2, 8'hFF);
        #1;
        check("grant_src1", 32'(src_ready), 3'b010);
        push_w(2 * HA + 5, 8'hFF, 1);
        step();
        set_src(1, 1'b0, 10'd0, 10'd0, 8'h00);
        tb_ptr = 2;
        repeat (5) step();
        hcount = 11'd5; vcount = 11'd2;
        step();
        check("raddr_mode0", 32'(fb_raddr), 1285);
        step(); step();
        check("rgb_not_yet", 32'(rgb), 12'hFFF);
        step();
        check("rgb_mode0_ff", 32'(rgb), 12'h000);
        hcount = 11'd0; vcount = 11'd0; blank = 1'b1;
        repeat (4) step();
        check("rgb_blank", 32'(rgb), 12'h000);
        blank = 1'b0;

        // All sources valid: grants rotate from the current pointer.
        for (int i = 0; i < N; i++) begin
            set_src(i, 1'b1, 10'(10 + i), 10'd3, 8'(8'h10 + i));
            gcnt[i] = 0;
        end
        for (int c = 0; c < 9; c++) begin
            #1;
            check("rr_grant", 32'(src_ready), 32'(1 << tb_ptr));
            push_w(3 * HA + 10 + tb_ptr, 8'(8'h10 + tb_ptr), 1);
            gcnt[tb_ptr]++;
            tb_ptr = (tb_ptr + 1) % N;
            step();
        end
        src_valid = '0;
        for (int i = 0; i < N; i++) check("rr_share", gcnt[i], 3);
        repeat (2) step();

        // Mode request only acts on frame_start; a second frame_start mid-clear is ignored.
        mode_req = 2'd1;
        repeat (5) step();
        check("no_change_midframe", 32'(mode_active), 0);
        check("no_busy_midframe", 32'(busy), 0);
        push_w(0, 8'h00, WW * WH);
        change_mode(2'd1);
        check("mode_now_1", 32'(mode_active), 1);
        src_valid = '1;
        #1;
        check("ready_in_clear", 32'(src_ready), 0);
        src_valid = '0;
        count_busy(100, n);
        mode_req = 2'd1;
        check("clear_len_mode1", n, WW * WH);
        check("mode_kept_1", 32'(mode_active), 1);

        // Windowed grayscale write and readback.
        set_src(0, 1'b1, 10'd3, 10'd1, 8'hA5);
        #1;
        check("grant_src0", 32'(src_ready), 3'b001);
        push_w(1 * WW + 3, 8'hA5, 1);
        step();
        set_src(0, 1'b0, 10'd0, 10'd0, 8'h00);
        step();
        hcount = 11'(WX + 3); vcount = 11'(WY + 1);
        step();
        check("raddr_win", 32'(fb_raddr), 387);
        repeat (3) step();
        check("rgb_gray", 32'(rgb), 12'hAAA);
        hcount = 11'd10;
        step();
        check("raddr_outside", 32'(fb_raddr), 0);
        repeat (3) step();
        check("rgb_outside", 32'(rgb), 12'h000);

        // False-colour mode.
        push_w(0, 8'h00, WW * WH);
        change_mode(2'd2);
        count_busy(-1, n);
        check("clear_len_mode2", n, WW * WH);
        set_src(0, 1'b1, 10'd3, 10'd1, 8'hA5);
        push_w(1 * WW + 3, 8'hA5, 1);
        step();
        set_src(0, 1'b0, 10'd0, 10'd0, 8'h00);
        step();
        hcount = 11'(WX + 3); vcount = 11'(WY + 1);
        repeat (4) step();
        check("rgb_false", 32'(rgb), 12'hA58);

        // Back to grayscale; boundary write and drops.
        push_w(0, 8'h00, WW * WH);
        change_mode(2'd1);
        count_busy(-1, n);
        check("clear_len_mode1b", n, WW * WH);
        set_src(0, 1'b1, 10'(WW - 1), 10'(WH - 1), 8'h3C);
        push_w((WH - 1) * WW + WW - 1, 8'h3C, 1);
        step();
        set_src(0, 1'b1, 10'(WW), 10'd0, 8'h11);
        #1;
        check("ready_on_drop", 32'(src_ready), 3'b001);
        step();
        check("drop_one", 32'(drop_cnt), 1);
        set_src(0, 1'b1, 10'd0, 10'(WH), 8'h22);
        repeat (299) step();
        set_src(0, 1'b0, 10'd0, 10'd0, 8'h00);
        check("drop_sat", 32'(drop_cnt), 255);
        check("no_we_on_drop", 32'(fb_we), 0);

        // Mode off: clear exits at once, rgb forced black.
        change_mode(2'd3);
        count_busy(-1, n);
        check("clear_len_mode3", n, 1);
        check("mode_now_3", 32'(mode_active), 3);
        hcount = 11'd5; vcount = 11'd2;
        repeat (4) step();
        check("rgb_off", 32'(rgb), 12'h000);

        // Reset 1000 cycles into a grayscale clear.
        push_w(0, 8'h00, 1000);
        change_mode(2'd1);
        repeat (1000) step();
        @(negedge clk);
        #1;
        reset = 1'b0;
        mode_req = 2'd0;
        #1;
        check_reset_outputs();
        push_w(0, 8'h00, HA * VA);
        repeat (2) step();
        @(negedge clk);
        reset = 1'b1;
        count_busy(-1, n);
        check("clear_len_after_rst", n, HA * VA);
        check("mode_after_rst", 32'(mode_active), 0);

        repeat (3) step();
        check("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_compositor.md
Name: display_compositor

Overview:
- Parametrised successor to the fixed 640x480 / 384x288 VGA buffer muxing in the top level.
- Arbitrates N_SRC pixel writers (rangefinder, disparity, camera, ...) onto the single VGA framebuffer BRAM write port.
- Generates framebuffer read addresses from VGA hcount/vcount and produces pipelined rgb.
- Applies display-mode changes only at frame boundaries, clearing the framebuffer before resuming writes.

Parameters:
N_SRC, 3, number of write sources
DATA_W, 8, pixel width
ADDR_W, 19, framebuffer address width
H_ACTIVE, 640, full-screen width
V_ACTIVE, 480, full-screen height
WIN_W, 384, window width
WIN_H, 288, window height
WIN_X, 128, window left column on screen
WIN_Y, 96, window top line on screen
RD_LAT, 2, framebuffer read latency in clk cycles

Ports:
clk  input  1  system clock; the only clock
reset  input  1  asynchronous, active-low reset
mode_req  input  2  requested mode: 0 full-screen map, 1 window grayscale, 2 window false-colour, 3 off
frame_start  input  1  one-cycle pulse at start of vertical blank
hcount  input  11  VGA column
vcount  input  11  VGA line
blank  input  1  VGA blanking
src_valid  input  N_SRC  per-source write request
src_x  input  N_SRC*10  per-source column, packed
src_y  input  N_SRC*10  per-source line, packed
src_data  input  N_SRC*DATA_W  per-source pixel, packed
src_ready  output  N_SRC  one-hot grant
fb_waddr  output  ADDR_W  framebuffer write address
fb_wdata  output  DATA_W  framebuffer write data
fb_we  output  1  framebuffer write enable
fb_raddr  output  ADDR_W  framebuffer read address
fb_rdata  input  DATA_W  framebuffer read data
rgb  output  12  pixel colour
mode_active  output  2  mode currently displayed
busy  output  1  high while clearing
drop_cnt  output  8  saturating count of out-of-range writes

Behaviour:
- Reset values: src_ready=0, fb_we=0, fb_waddr=0, fb_wdata=0, fb_raddr=0, rgb=0, mode_active=0, drop_cnt=0, state=CLEAR, clear address=0.
- FSM states RUN and CLEAR.
  - CLEAR: src_ready=0, busy=1. Writes fb_wdata=0 at consecutive addresses 0..LIMIT-1, one per cycle.
  - LIMIT is H_ACTIVE*V_ACTIVE for mode 0, WIN_W*WIN_H for modes 1 and 2, and 0 for mode 3 (exits immediately).
  - CLEAR goes to RUN on the cycle after the write at LIMIT-1.
- Mode changes:
  - In RUN, mode_req is sampled on frame_start. If it differs from mode_active: update mode_active, reset the clear address, enter CLEAR.
  - frame_start during CLEAR is ignored.
  - An asserted reset mid-clear returns to CLEAR from address 0 with mode 0.
- Arbitration (RUN only):
  - Round-robin grant. Priority pointer starts at source 0 and moves to granted+1 (mod N_SRC) after each grant.
  - src_ready is combinational from src_valid and the pointer; at most one bit set.
  - A transfer is valid&ready. The write appears on fb_* one cycle later (registered).
  - A source holds x/y/data stable until ready.
- Write address:
  - Mode 0: y*H_ACTIVE+x. Modes 1/2: y*WIN_W+x.
  - Coordinates at or beyond the mode width/height are accepted (ready) but not written; drop_cnt increments and saturates at 255.
  - In mode 3 all transfers are dropped.
- Read path:
  - Mode 0: fb_raddr = vcount*H_ACTIVE+hcount, registered.
  - Windowed modes: when inside the window, fb_raddr = (vcount-WIN_Y)*WIN_W + (hcount-WIN_X); outside the window, fb_raddr = 0.
  - blank and the in-window flag are delayed to align with fb_rdata.
  - rgb latency from hcount/vcount is RD_LAT+2 cycles, constant.
- rgb mapping, forced to 0 when blank, in CLEAR, or in mode 3:
  - Mode 0: data==all-ones gives 000, else FFF.
  - Mode 1: {d[7:4],d[7:4],d[7:4]}.
  - Mode 2: {d[7:4],~d[7:4],4'h8}.
  - Modes 1/2 outside the window: 000.
- Multiplies map to DSPs or shift-add. No wrap-around occurs since addresses are below 2^ADDR_W.

Decomposition:
- Package display_pkg: mode encoding constants (MODE_MAP, MODE_GRAY, MODE_FALSE, MODE_OFF), the state enum, and the rgb constants BLACK/WHITE.
- Sub-module rr_arbiter, parametrised on N: valid in, one-hot grant out, pointer register, advance on grant.

Test Plan:
- Release reset with mode_req=0 -> busy for exactly 307200 cycles, addresses 0..307199 written with 0, then src_ready is permitted.
- Mode 0 RUN, source 1 writes x=5,y=2,data=FF -> fb_we one cycle later, fb_waddr=1285, fb_wdata=FF; rgb=000 at hcount=5,vcount=2 after RD_LAT+2 cycles.
- All three sources valid continuously -> grants rotate 0,1,2,0,... with each source getting 1 of every 3 cycles and no double grant.
- Set mode_req=1 mid-frame -> no change until frame_start; then mode_active=1, busy for 110592 cycles; a second frame_start during the clear changes nothing.
- Mode 1, write x=384,y=0 -> ready asserted, no fb_we, drop_cnt 0->1; 300 such writes -> drop_cnt stays at 255.
- Assert reset 1000 cycles into a mode 1 clear -> all outputs are the reset values; after release, mode_active=0 and the clear restarts at address 0 with LIMIT 307200.
